// File: rtl/fifo_prog_pkg.sv
// Shared defaults, depth helper and operation encoding for fifo_prog.
// Define FIFO_PROG_FWFT_EN to build fifo_prog with a first-word fall-through read port.
package fifo_prog_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 4;
  localparam int unsigned DEF_BUF_WIDTH  = 3;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int unsigned fifo_depth(input int unsigned buf_width);
    return 32'd1 << buf_width;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// 2**BUF_WIDTH x DATA_WIDTH register array: synchronous write, asynchronous read.
module fifo_mem
  import fifo_prog_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BUF_WIDTH  = DEF_BUF_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [BUF_WIDTH-1:0]  i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [BUF_WIDTH-1:0]  i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = fifo_depth(BUF_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_prog.sv
// Parametrised synchronous FIFO with programmable almost flags and sticky error flags.
// Macro FIFO_PROG_FWFT_EN selects a first-word fall-through read port; default is registered read.
module fifo_prog
  import fifo_prog_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BUF_WIDTH  = DEF_BUF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] buf_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] buf_out,
  input  logic [BUF_WIDTH:0]    af_thresh,
  input  logic [BUF_WIDTH:0]    ae_thresh,
  input  logic                  err_clr,
  output logic                  buf_full,
  output logic                  buf_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [BUF_WIDTH:0]    fifo_counter
);

  localparam int unsigned          DEPTH    = fifo_depth(BUF_WIDTH);
  localparam logic [BUF_WIDTH:0]   CNT_FULL = (BUF_WIDTH+1)'(DEPTH);
  localparam logic [BUF_WIDTH:0]   CNT_ONE  = (BUF_WIDTH+1)'(1);
  localparam logic [BUF_WIDTH-1:0] PTR_ONE  = BUF_WIDTH'(1);

  logic [BUF_WIDTH-1:0]  r_wr_ptr, r_rd_ptr;
  logic [BUF_WIDTH:0]    r_count;
  logic                  r_overflow, r_underflow;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_full, w_empty, w_push, w_pop, w_ovf_evt, w_unf_evt;
  fifo_op_e              w_op;

  // A push while full is accepted only alongside a pop: it lands in the slot
  // being freed, and the async read captures the old word before the write.
  always_comb begin
    w_full    = (r_count == CNT_FULL);
    w_empty   = (r_count == '0);
    w_push    = wr_en && (!w_full || rd_en);
    w_pop     = rd_en && !w_empty;
    w_ovf_evt = wr_en && w_full && !rd_en;
    w_unf_evt = rd_en && w_empty;
    w_op      = fifo_op_e'({w_push, w_pop});
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_WIDTH  (BUF_WIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (buf_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case (w_op)
        OP_PUSH: r_count <= r_count + CNT_ONE;
        OP_POP:  r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      // A new error event outranks a simultaneous clear.
      r_overflow  <= w_ovf_evt || (r_overflow  && !err_clr);
      r_underflow <= w_unf_evt || (r_underflow && !err_clr);
    end
  end

`ifdef FIFO_PROG_FWFT_EN
  assign buf_out = w_empty ? '0 : w_rdata;
`else
  logic [DATA_WIDTH-1:0] r_buf_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_buf_out <= '0;
    else if (w_pop) r_buf_out <= w_rdata;
  end

  assign buf_out = r_buf_out;
`endif

  assign buf_full     = w_full;
  assign buf_empty    = w_empty;
  assign almost_full  = (r_count >= af_thresh);
  assign almost_empty = (r_count <= ae_thresh);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign fifo_counter = r_count;

endmodule

// File: tb/tb_fifo_prog.sv
// Scoreboard bench for fifo_prog (DATA_WIDTH=4, BUF_WIDTH=3); honours FIFO_PROG_FWFT_EN.
`timescale 1ns/1ps
module tb_fifo_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [3:0] buf_in = '0;
  logic [3:0] buf_out;
  logic [3:0] af_thresh = 4'd0, ae_thresh = 4'd1;
  logic       buf_full, buf_empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] fifo_counter;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [3:0] m_q[$];
  logic [3:0] m_out = '0;
  bit         m_ovf = 1'b0, m_unf = 1'b0;
  int         m_cnt = 0;

  fifo_prog #(
    .DATA_WIDTH (4),
    .BUF_WIDTH  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .buf_in       (buf_in),
    .rd_en        (rd_en),
    .buf_out      (buf_out),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .err_clr      (err_clr),
    .buf_full     (buf_full),
    .buf_empty    (buf_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .fifo_counter (fifo_counter)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_status();
    check("cnt",   32'(fifo_counter), 32'(m_cnt));
    check("full",  32'(buf_full),     32'(m_cnt == 8));
    check("empty", 32'(buf_empty),    32'(m_cnt == 0));
    check("af",    32'(almost_full),  32'(m_cnt >= int'(af_thresh)));
    check("ae",    32'(almost_empty), 32'(m_cnt <= int'(ae_thresh)));
    check("ovf",   32'(overflow),     32'(m_ovf));
    check("unf",   32'(underflow),    32'(m_unf));
  endtask

  // One clock of stimulus; the model predicts everything from the pre-edge state.
  task automatic cycle(input logic wr, input logic [3:0] din, input logic rd, input logic clr);
    bit push_ok, pop_ok;
    wr_en = wr; buf_in = din; rd_en = rd; err_clr = clr;
    push_ok = wr && (m_cnt != 8 || rd);
    pop_ok  = rd && (m_cnt != 0);
`ifdef FIFO_PROG_FWFT_EN
    #1 check("fwft_out", 32'(buf_out), (m_cnt == 0) ? 32'd0 : 32'(m_q[0]));
`endif
    @(posedge clk); #1;
    m_ovf = (wr && m_cnt == 8 && !rd) || (m_ovf && !clr);
    m_unf = (rd && m_cnt == 0) || (m_unf && !clr);
    if (pop_ok)  m_out = m_q.pop_front();
    if (push_ok) m_q.push_back(din);
    m_cnt = m_q.size();
    check_status();
`ifndef FIFO_PROG_FWFT_EN
    check("buf_out", 32'(buf_out), 32'(m_out));
`endif
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic model_reset();
    m_q.delete(); m_cnt = 0; m_out = '0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  initial begin
    logic [3:0] drain_exp [8];
    drain_exp = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12};

    // reset state; af_thresh==0 forces almost_full
    #3;
    check("rst_af0", 32'(almost_full), 32'd1);
    af_thresh = 4'd6;
    #1;
    check_status();
    check("rst_out", 32'(buf_out), 32'd0);
    #8 rst = 1'b0;

    // fill 1..8, then overflow push of 9
    for (int i = 1; i <= 8; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
    check("fill_cnt", 32'(fifo_counter), 32'd8);
    cycle(1'b1, 4'd9, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_cnt", 32'(fifo_counter), 32'd8);

    // simultaneous push/pop while full
    cycle(1'b1, 4'd12, 1'b1, 1'b0);
    check("full_rw_cnt", 32'(fifo_counter), 32'd8);
`ifndef FIFO_PROG_FWFT_EN
    check("full_rw_out", 32'(buf_out), 32'd1);
`endif
    for (int i = 0; i < 8; i++) begin
`ifdef FIFO_PROG_FWFT_EN
      check("drain_fwft", 32'(buf_out), 32'(drain_exp[i]));
`endif
      cycle(1'b0, 4'd0, 1'b1, 1'b0);
`ifndef FIFO_PROG_FWFT_EN
      check("drain", 32'(buf_out), 32'(drain_exp[i]));
`endif
    end
    check("drained_empty", 32'(buf_empty), 32'd1);

    // simultaneous push/pop while empty: write only, underflow set
    cycle(1'b1, 4'd5, 1'b1, 1'b0);
    check("empty_rw_cnt", 32'(fifo_counter), 32'd1);
    check("empty_rw_unf", 32'(underflow), 32'd1);
`ifndef FIFO_PROG_FWFT_EN
    check("empty_rw_hold", 32'(buf_out), 32'd12);
`endif
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
`ifndef FIFO_PROG_FWFT_EN
    check("pop5", 32'(buf_out), 32'd5);
`endif

    // error clear, then clear racing a new underflow
    cycle(1'b0, 4'd0, 1'b0, 1'b1);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_unf", 32'(underflow), 32'd0);
    cycle(1'b0, 4'd0, 1'b1, 1'b1);
    check("clr_vs_unf", 32'(underflow), 32'd1);
    cycle(1'b0, 4'd0, 1'b0, 1'b1);

`ifdef FIFO_PROG_FWFT_EN
    cycle(1'b1, 4'd7, 1'b0, 1'b0);
    cycle(1'b1, 4'd4, 1'b0, 1'b0);
    check("fwft_first", 32'(buf_out), 32'd7);
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
    check("fwft_next", 32'(buf_out), 32'd4);
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
`endif

    // threshold change mid-stream, out-of-range thresholds, async reset
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(10 + i), 1'b0, 1'b0);
    check("af_before", 32'(almost_full), 32'd0);
    af_thresh = 4'd2;
    #1 check("af_live", 32'(almost_full), 32'd1);
    af_thresh = 4'd9; ae_thresh = 4'd15;
    #1 check("af_over", 32'(almost_full), 32'd0);
    check("ae_over", 32'(almost_empty), 32'd1);
    af_thresh = 4'd6; ae_thresh = 4'd1;
    #1 rst = 1'b1;
    #1 model_reset();
    check_status();
    check("rst_mid_out", 32'(buf_out), 32'd0);
    #2 rst = 1'b0;

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) begin
        af_thresh = 4'($urandom_range(0, 10));
        ae_thresh = 4'($urandom_range(0, 10));
      end
      cycle(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
